// File: rtl/mul4_mac_seq_if.sv
// mul4_mac_seq_if: operand, multiplier and group-sum handshake bundle for mul4_mac_seq.
interface mul4_mac_seq_if #(parameter int ACC_W = 12);
  logic             IN_VALID;
  logic             IN_READY;
  logic [3:0]       IN_A;
  logic [3:0]       IN_B;
  logic             IN_LAST;
  logic             MUL_START;
  logic [3:0]       MUL_A;
  logic [3:0]       MUL_B;
  logic             MUL_READY;
  logic [7:0]       MUL_P;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [ACC_W-1:0] OUT_SUM;
  logic             OUT_OVF;
  logic             ERR_TMO;
  modport slave (
    input  IN_VALID, IN_A, IN_B, IN_LAST, MUL_READY, MUL_P, OUT_READY,
    output IN_READY, MUL_START, MUL_A, MUL_B, OUT_VALID, OUT_SUM, OUT_OVF, ERR_TMO
  );
  modport master (
    output IN_VALID, IN_A, IN_B, IN_LAST, MUL_READY, MUL_P, OUT_READY,
    input  IN_READY, MUL_START, MUL_A, MUL_B, OUT_VALID, OUT_SUM, OUT_OVF, ERR_TMO
  );
endinterface

// File: rtl/mul4_mac_seq.sv
// mul4_mac_seq: feeds operand pairs to a 4x4 shift-add multiplier and accumulates group sums.
module mul4_mac_seq #(
  parameter int ACC_W = 12,
  parameter int TMO   = 15
) (
  input logic           CK,
  input logic           RN,
  mul4_mac_seq_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT_LO = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_ACC     = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;
  localparam logic [7:0] TMO_C     = 8'(TMO);
  logic [2:0]       state_q, state_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic             last_q, last_d, start_q, valid_q;
  logic [7:0]       prod_q, prod_d, tmo_q, tmo_d, tmo_inc;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d, err_q, err_d;
  logic [ACC_W:0]   sum;
  assign tmo_inc = tmo_q + 8'd1;
  assign sum     = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, prod_q};
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (bus.IN_VALID) begin
        a_d     = bus.IN_A;
        b_d     = bus.IN_B;
        last_d  = bus.IN_LAST;
        state_d = S_START;
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO, S_WAIT_HI: begin
        tmo_d = tmo_inc;
        // a real completion on the final allowed cycle wins over the timeout
        if (state_q == S_WAIT_HI && bus.MUL_READY) begin
          prod_d  = bus.MUL_P;
          state_d = S_ACC;
        end else if (tmo_inc == TMO_C) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_ACC;
        end else if (state_q == S_WAIT_LO && !bus.MUL_READY) begin
          state_d = S_WAIT_HI;
        end
      end
      S_ACC: begin
        acc_d   = sum[ACC_W-1:0];
        ovf_d   = ovf_q | sum[ACC_W];
        state_d = last_q ? S_OUT : S_IDLE;
      end
      S_OUT: if (valid_q && bus.OUT_READY) begin
        acc_d   = '0;
        ovf_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b0;
      prod_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      start_q <= state_d == S_START;
      valid_q <= state_d == S_OUT;
    end
  end
  assign bus.IN_READY  = state_q == S_IDLE;
  assign bus.MUL_START = start_q;
  assign bus.MUL_A     = a_q;
  assign bus.MUL_B     = b_q;
  assign bus.OUT_VALID = valid_q;
  assign bus.OUT_SUM   = acc_q;
  assign bus.OUT_OVF   = ovf_q;
  assign bus.ERR_TMO   = err_q;
endmodule

// File: tb/tb_mul4_mac_seq.sv
// tb_mul4_mac_seq: directed vectors against a 12-bit and an 8-bit accumulator instance in lockstep.
module tb_mul4_mac_seq;
  logic       CK = 1'b0;
  logic       RN = 1'b1;
  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic       never_lo = 1'b0;
  int         stale = 0;
  logic       busy = 1'b0;
  int         cnt = 0;
  logic [7:0] p_q = '0;
  logic       mul_ready;
  logic [7:0] mul_p;
  int         n_vec = 0, n_err = 0;
  always #5 CK = ~CK;
  mul4_mac_seq_if #(.ACC_W(12)) u_if ();
  mul4_mac_seq_if #(.ACC_W(8))  v_if ();
  assign u_if.IN_VALID  = in_valid;
  assign u_if.IN_A      = in_a;
  assign u_if.IN_B      = in_b;
  assign u_if.IN_LAST   = in_last;
  assign u_if.OUT_READY = out_ready;
  assign u_if.MUL_READY = mul_ready;
  assign u_if.MUL_P     = mul_p;
  assign v_if.IN_VALID  = in_valid;
  assign v_if.IN_A      = in_a;
  assign v_if.IN_B      = in_b;
  assign v_if.IN_LAST   = in_last;
  assign v_if.OUT_READY = out_ready;
  assign v_if.MUL_READY = mul_ready;
  assign v_if.MUL_P     = mul_p;
  mul4_mac_seq #(.ACC_W(12), .TMO(15)) u_dut (.CK(CK), .RN(RN), .bus(u_if));
  mul4_mac_seq #(.ACC_W(8),  .TMO(15)) v_dut (.CK(CK), .RN(RN), .bus(v_if));
  // multiplier model: READY stays high 'stale' cycles after START, low for 5, then high with A*B
  always @(posedge CK) begin
    if (u_if.MUL_START) begin
      busy <= 1'b1;
      cnt  <= 0;
    end else if (busy) begin
      cnt <= cnt + 1;
      if (cnt == stale + 4) begin
        busy <= 1'b0;
        p_q  <= 8'(u_if.MUL_A) * 8'(u_if.MUL_B);
      end
    end
  end
  assign mul_ready = never_lo | !busy | (cnt < stale);
  assign mul_p     = never_lo ? 8'hAA : p_q;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last, input int exp_cyc, input string tag);
    int   k = 0, cyc = 0, n_st = 0;
    logic ab_ok = 1'b1;
    @(negedge CK);
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    while (!u_if.IN_READY && k < 50) begin
      @(negedge CK);
      k++;
    end
    chk({tag, "_accept"}, 32'(u_if.IN_READY), 1);
    @(posedge CK);
    #1 in_valid = 1'b0;
    while (cyc < 100) begin
      @(negedge CK);
      if (u_if.IN_READY || u_if.OUT_VALID) break;
      cyc++;
      n_st += int'(u_if.MUL_START);
      if (u_if.MUL_A !== a || u_if.MUL_B !== b) ab_ok = 1'b0;
    end
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_starts"}, n_st, 1);
    chk({tag, "_ab_stable"}, 32'(ab_ok), 1);
  endtask
  task automatic take(input int e12, input int o12, input int e8, input int o8, input string tag);
    int k = 0;
    while (!u_if.OUT_VALID && k < 100) begin
      @(negedge CK);
      k++;
    end
    chk({tag, "_valid"}, 32'(u_if.OUT_VALID), 1);
    chk({tag, "_sum12"}, 32'(u_if.OUT_SUM), e12);
    chk({tag, "_ovf12"}, 32'(u_if.OUT_OVF), o12);
    chk({tag, "_sum8"}, 32'(v_if.OUT_SUM), e8);
    chk({tag, "_ovf8"}, 32'(v_if.OUT_OVF), o8);
    out_ready = 1'b1;
    @(posedge CK);
    #1 out_ready = 1'b0;
    @(negedge CK);
    chk({tag, "_drop"}, 32'(u_if.OUT_VALID), 0);
    chk({tag, "_idle"}, 32'(u_if.IN_READY), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int ns;
    #2 RN = 1'b0;
    #1;
    chk("rst_in_ready", 32'(u_if.IN_READY), 1);
    chk("rst_start", 32'(u_if.MUL_START), 0);
    chk("rst_ab", {24'd0, u_if.MUL_A, u_if.MUL_B}, 0);
    chk("rst_valid", 32'(u_if.OUT_VALID), 0);
    chk("rst_sum", 32'(u_if.OUT_SUM), 0);
    chk("rst_ovf_err", {30'd0, u_if.OUT_OVF, u_if.ERR_TMO}, 0);
    repeat (2) @(negedge CK);
    RN = 1'b1;
    send(4'd3, 4'd5, 1'b1, 8, "t1");
    take(15, 0, 15, 0, "t1");
    send(4'd15, 4'd15, 1'b0, 8, "g2a");
    send(4'd7, 4'd9, 1'b0, 8, "g2b");
    send(4'd0, 4'd12, 1'b1, 8, "g2c");
    repeat (4) begin
      @(negedge CK);
      chk("hold_valid", 32'(u_if.OUT_VALID), 1);
      chk("hold_sum", 32'(u_if.OUT_SUM), 288);
    end
    take(288, 0, 32, 1, "g2");
    send(4'd15, 4'd15, 1'b0, 8, "o1");
    send(4'd15, 4'd15, 1'b1, 8, "o2");
    take(450, 0, 194, 1, "ovf");
    send(4'd1, 4'd1, 1'b1, 8, "o3");
    take(1, 0, 1, 0, "ovf_next");
    chk("tmo_err_before", 32'(u_if.ERR_TMO), 0);
    never_lo = 1'b1;
    send(4'd9, 4'd9, 1'b0, 17, "tmo");
    chk("tmo_err_set", 32'(u_if.ERR_TMO), 1);
    never_lo = 1'b0;
    send(4'd2, 4'd3, 1'b1, 8, "tmo_next");
    take(6, 0, 6, 0, "tmo_next");
    chk("tmo_err_sticky", 32'(u_if.ERR_TMO), 1);
    send(4'd5, 4'd8, 1'b0, 8, "r40");
    @(negedge CK);
    in_a = 4'd2; in_b = 4'd2; in_last = 1'b0; in_valid = 1'b1;
    @(posedge CK);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge CK);
    #2 RN = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(u_if.IN_READY), 1);
    chk("mid_rst_start", 32'(u_if.MUL_START), 0);
    chk("mid_rst_ab", {24'd0, u_if.MUL_A, u_if.MUL_B}, 0);
    chk("mid_rst_sum", 32'(u_if.OUT_SUM), 0);
    chk("mid_rst_flags", {29'd0, u_if.OUT_VALID, u_if.OUT_OVF, u_if.ERR_TMO}, 0);
    @(negedge CK);
    RN = 1'b1;
    ns = 0;
    repeat (10) begin
      @(negedge CK);
      ns += int'(u_if.MUL_START);
    end
    chk("mid_rst_no_restart", ns, 0);
    send(4'd1, 4'd4, 1'b1, 8, "post_rst");
    take(4, 0, 4, 0, "post_rst");
    stale = 2;
    send(4'd3, 4'd7, 1'b1, 10, "stale");
    take(21, 0, 21, 0, "stale");
    stale = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mul4_mac_seq.md
Name: mul4_mac_seq

Overview:
- Operand sequencer and accumulator placed directly upstream and downstream of the 4x4 shift-add multiplier (CK/START/A/B in, P/READY out).
- Accepts operand pairs over a valid/ready handshake and issues one START pulse per pair, with A/B held stable for the whole multiply.
- Captures the 8-bit product on completion and sums the products of a group into an accumulator.
- Presents each group sum on an output valid/ready handshake.

Parameters:
ACC_W, 12, accumulator and OUT_SUM width in bits; legal range is 8..16.
TMO, 15, maximum cycles spent waiting in WAIT_LO plus WAIT_HI before a timeout; legal range is 8..255.

Ports:
CK  in  1  clock, rising edge
RN  in  1  reset, asynchronous, active-low
IN_VALID  in  1  operand pair valid
IN_READY  out  1  block can accept an operand pair
IN_A  in  4  multiplicand
IN_B  in  4  multiplier
IN_LAST  in  1  this pair closes the group
MUL_START  out  1  to multiplier START
MUL_A  out  4  to multiplier A3..A0
MUL_B  out  4  to multiplier B3..B0
MUL_READY  in  1  from multiplier READY
MUL_P  in  8  from multiplier P7..P0
OUT_VALID  out  1  group sum valid
OUT_READY  in  1  consumer accepts the sum
OUT_SUM  out  ACC_W  group sum
OUT_OVF  out  1  group sum wrapped
ERR_TMO  out  1  sticky timeout flag

Behaviour:
- Reset (RN=0, asynchronous):
  - state=IDLE; all outputs 0 except IN_READY=1.
  - Accumulator, MUL_A, MUL_B, LAST register, timeout counter and ERR_TMO all clear.
  - Reset during a multiply abandons it; the multiplier is not re-started.
- All outputs are registered, except IN_READY, which is decoded from state.
- States: IDLE, START, WAIT_LO, WAIT_HI, ACC, OUT.
- IDLE:
  - IN_READY=1.
  - On IN_VALID=1: latch IN_A→MUL_A, IN_B→MUL_B and IN_LAST, then go to START.
- START:
  - MUL_START=1 for exactly one cycle; go to WAIT_LO.
  - Clear the timeout counter.
- WAIT_LO:
  - Wait for MUL_READY=0. This is needed because READY can still be high from the previous operation.
  - When MUL_READY=0, go to WAIT_HI.
- WAIT_HI:
  - On the first cycle with MUL_READY=1, register MUL_P into the product register and go to ACC.
- MUL_A and MUL_B stay constant from START until ACC is entered.
- Timeout:
  - The counter increments every cycle spent in WAIT_LO or WAIT_HI.
  - When the count reaches TMO: set ERR_TMO, use a product of 0, and go to ACC.
  - ERR_TMO clears only on reset.
- ACC:
  - acc = acc + zero-extended product, modulo 2^ACC_W.
  - A carry out of bit ACC_W-1 sets the group overflow flag.
  - If LAST=1, go to OUT; otherwise go to IDLE.
- OUT:
  - OUT_VALID=1; OUT_SUM and OUT_OVF are held stable.
  - On OUT_READY=1: clear the accumulator and overflow flag, drop OUT_VALID on the next cycle, go to IDLE.
  - OUT_READY with OUT_VALID=0 has no effect.
- IN_READY=0 in every state except IDLE, so no new pair overlaps a multiply or a pending output.
- Per-pair latency: accept at cycle 0, START at cycle 1, ACC at (cycle where READY is seen high)+1, IDLE or OUT one cycle after ACC.
- A pending OUT never drops data: the sum is held indefinitely until OUT_READY.

Test Plan:
- Reset, then one pair A=3, B=5, LAST=1; multiplier model drops READY for 5 cycles → exactly one MUL_START pulse; MUL_A=3 and MUL_B=5 stable throughout; OUT_VALID with OUT_SUM=15, OUT_OVF=0.
- Group of three pairs (15,15), (7,9), (0,12), last on the third → OUT_SUM=288; IN_READY=0 throughout each multiply; OUT_READY held low 4 cycles → sum held, then cleared on accept.
- ACC_W=8, group (15,15), (15,15) → OUT_SUM=194, OUT_OVF=1; next group (1,1) → OUT_SUM=1, OUT_OVF=0.
- Multiplier model never lowers READY → after TMO=15 wait cycles ERR_TMO=1 and the product counts as 0; the next normal pair (2,3, last) yields OUT_SUM=6 and ERR_TMO stays 1.
- RN pulsed low in WAIT_HI with acc=40 → outputs return to reset values immediately; after release, pair (1,4, last) → OUT_SUM=4.
- Stale READY: model holds READY=1 for 2 cycles after START before dropping → product is not captured early; final OUT_SUM equals the correct A*B.
